// File: rtl/sumador_restador_n_bits.sv
// N-bit two's-complement ripple-carry adder/subtractor with registered result, carry and overflow.
// Optional macro SUMRES_ZERO_FLAG_EN adds a registered zero flag output oZero.
module sumador_restador_n_bits #(
   parameter int unsigned NBITS = 4
) (
   input  logic             iClk,
   input  logic             iRst_n,
   input  logic             iOp,
   input  logic [NBITS-1:0] iX,
   input  logic [NBITS-1:0] iY,
   output logic [NBITS-1:0] oS,
   output logic             oCout,
`ifdef SUMRES_ZERO_FLAG_EN
   output logic             oZero,
`endif
   output logic             oOverflow
);

   logic [NBITS-1:0] y_eff;
   logic [NBITS:0]   carry;
   logic [NBITS-1:0] s_d, s_q;
   logic             cout_d, cout_q;
   logic             ovf_d, ovf_q;

   // Subtraction is X + ~Y + 1: invert Y and inject iOp as the carry-in.
   assign carry[0] = iOp;

   for (genvar i = 0; i < NBITS; i++) begin : g_fa
      assign y_eff[i]   = iY[i] ^ iOp;
      assign s_d[i]     = iX[i] ^ y_eff[i] ^ carry[i];
      assign carry[i+1] = (iX[i] & y_eff[i]) | (carry[i] & (iX[i] ^ y_eff[i]));
   end

   assign cout_d = carry[NBITS];
   assign ovf_d  = carry[NBITS] ^ carry[NBITS-1];

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         s_q    <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         s_q    <= s_d;
         cout_q <= cout_d;
         ovf_q  <= ovf_d;
      end
   end

   assign oS        = s_q;
   assign oCout     = cout_q;
   assign oOverflow = ovf_q;

`ifdef SUMRES_ZERO_FLAG_EN
   logic zero_q;

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         zero_q <= 1'b0;
      end else begin
         zero_q <= (s_d == '0);
      end
   end

   assign oZero = zero_q;
`endif

endmodule

// File: tb/tb_sumador_restador_n_bits.sv
// Directed and exhaustive self-checking bench for sumador_restador_n_bits at NBITS=4.
module tb_sumador_restador_n_bits;

   localparam int unsigned NBITS = 4;

   logic             iClk;
   logic             iRst_n;
   logic             iOp;
   logic [NBITS-1:0] iX;
   logic [NBITS-1:0] iY;
   logic [NBITS-1:0] oS;
   logic             oCout;
   logic             oOverflow;
`ifdef SUMRES_ZERO_FLAG_EN
   logic             oZero;
`endif

   int n_cmp;
   int n_err;

   sumador_restador_n_bits #(.NBITS(NBITS)) dut (
      .iClk      (iClk),
      .iRst_n    (iRst_n),
      .iOp       (iOp),
      .iX        (iX),
      .iY        (iY),
      .oS        (oS),
      .oCout     (oCout),
`ifdef SUMRES_ZERO_FLAG_EN
      .oZero     (oZero),
`endif
      .oOverflow (oOverflow)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag, input int s, input int c, input int v);
      check_eq({tag, ".S"}, 32'(oS), 32'(s));
      check_eq({tag, ".Cout"}, 32'(oCout), 32'(c));
      check_eq({tag, ".Ovf"}, 32'(oOverflow), 32'(v));
`ifdef SUMRES_ZERO_FLAG_EN
      check_eq({tag, ".Zero"}, 32'(oZero), (iRst_n_sampled && s == 0) ? 32'd1 : 32'd0);
`endif
   endtask

   // Reset state of the zero flag differs from "result is zero"; track whether the last edge was a reset.
   logic iRst_n_sampled;
   always @(posedge iClk) iRst_n_sampled <= iRst_n;

   // Drive one operation, clock it, and check the registered result.
   task automatic op_check(input string tag, input logic op, input int x, input int y,
                           input int s, input int c, input int v);
      iOp = op;
      iX  = NBITS'(x);
      iY  = NBITS'(y);
      @(posedge iClk);
      #1;
      check_outs(tag, s, c, v);
   endtask

   initial begin
      logic [4:0] sum;
      logic [3:0] ye;
      logic [3:0] xs;
      logic       vexp;

      n_cmp = 0;
      n_err = 0;

      // Reset with busy inputs held for two edges.
      iRst_n = 1'b0;
      iOp    = 1'b1;
      iX     = 4'd15;
      iY     = 4'd15;
      @(posedge iClk);
      @(posedge iClk);
      #1;
      check_outs("rst", 0, 0, 0);
      iRst_n = 1'b1;
      @(posedge iClk);
      #1;
      check_outs("rst_rel_15m15", 0, 1, 0);

      op_check("add_3p4",  1'b0, 3, 4, 7, 0, 0);
      op_check("add_7p1",  1'b0, 7, 1, 8, 0, 1);
      op_check("add_15p1", 1'b0, 15, 1, 0, 1, 0);
      op_check("add_8p8",  1'b0, 8, 8, 0, 1, 1);

      op_check("sub_5m3",  1'b1, 5, 3, 2, 1, 0);
      op_check("sub_3m5",  1'b1, 3, 5, 14, 0, 0);
      op_check("sub_8m1",  1'b1, 8, 1, 7, 1, 1);
      op_check("sub_0m0",  1'b1, 0, 0, 0, 1, 0);
      op_check("sub_0m8",  1'b1, 0, 8, 8, 0, 1);

      // Alternate op each cycle; outputs must not follow inputs until the next edge.
      for (int k = 0; k < 4; k++) begin
         logic op;
         op = k[0];
         op_check(op ? "tog_sub" : "tog_add", op, 6, 2, op ? 4 : 8, op ? 1 : 0, op ? 0 : 1);
         iOp = ~op;
         #1;
         check_eq("tog_lag.S", 32'(oS), op ? 32'd4 : 32'd8);
      end

      // Mid-stream reset discards the pending result.
      op_check("mid_7p1", 1'b0, 7, 1, 8, 0, 1);
      iRst_n = 1'b0;
      @(posedge iClk);
      #1;
      check_outs("mid_rst", 0, 0, 0);
      iRst_n = 1'b1;
      op_check("mid_resume_3p4", 1'b0, 3, 4, 7, 0, 0);

      // Exhaustive sweep against a 5-bit reference sum.
      for (int op = 0; op < 2; op++) begin
         for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
               xs   = 4'(x);
               ye   = 4'(y) ^ {4{op[0]}};
               sum  = 5'(xs) + 5'(ye) + 5'(op[0]);
               vexp = (xs[3] == ye[3]) && (sum[3] != xs[3]);
               iOp  = op[0];
               iX   = 4'(x);
               iY   = 4'(y);
               @(posedge iClk);
               #1;
               check_outs("sweep", int'(sum[3:0]), int'(sum[4]), int'(vexp));
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
